register_file_mp: RTL and testbench

Parametrised multi-port register file with a per-register pending (scoreboard) bit. It is the generalised successor of the 16 x 16-bit register file in the single-cycle processor, with configurable data width and depth, two write ports (ALU writeback and load return), optional write-to-read bypass, an optional hardwired zero register, and producer tracking for the decode stage of the pipelined processor.

---
 rtl/register_file_mp.sv | 104 ++++++++++
 tb/tb_register_file_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with two write ports, optional
// write-to-read bypass, optional hardwired zero register and a pending bit per register.
module register_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic [ADDR_W-1:0] DstReg2,
    input  logic              WriteReg2,
    input  logic [DATA_W-1:0] DstData2,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic              IssueValid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [DEPTH-1:0]  wr_a_s;
    logic [DEPTH-1:0]  wr_b_s;
    logic [DEPTH-1:0]  iss_s;
    logic [ADDR_W-1:0] src_s [2];

    assign src_s[0] = SrcReg1;
    assign src_s[1] = SrcReg2;

    // One-hot decode of write and issue targets; register 0 is masked when hardwired.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            wr_a_s[r] = ((ZERO_REG == 0) || (r != 0)) && WriteReg   && (DstReg   == ADDR_W'(r));
            wr_b_s[r] = ((ZERO_REG == 0) || (r != 0)) && WriteReg2  && (DstReg2  == ADDR_W'(r));
            iss_s[r]  = ((ZERO_REG == 0) || (r != 0)) && IssueValid && (IssueReg == ADDR_W'(r));
        end
    end

    // Register contents and pending bits; port A beats port B, issue beats completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
            end
            pend_r <= {DEPTH{1'b0}};
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_a_s[r]) begin
                    regs_r[r] <= DstData;
                end else if (wr_b_s[r]) begin
                    regs_r[r] <= DstData2;
                end
                if (iss_s[r]) begin
                    pend_r[r] <= 1'b1;
                end else if (wr_a_s[r] || wr_b_s[r]) begin
                    pend_r[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic              hit_a_s;
        logic              hit_b_s;
        logic              zero_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        // Read mux: reset and the zero register dominate, then bypass, then storage.
        always_comb begin
            hit_a_s = (BYPASS != 0) && WriteReg  && (DstReg  == src_s[p]);
            hit_b_s = (BYPASS != 0) && WriteReg2 && (DstReg2 == src_s[p]);
            zero_s  = (ZERO_REG != 0) && (src_s[p] == {ADDR_W{1'b0}});
            if (rst || zero_s) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (hit_a_s) begin
                data_s = DstData;
                busy_s = 1'b0;
            end else if (hit_b_s) begin
                data_s = DstData2;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[src_s[p]];
                busy_s = pend_r[src_s[p]];
            end
        end
    end

    assign SrcData1 = g_rd[0].data_s;
    assign SrcData2 = g_rd[1].data_s;
    assign Busy1    = g_rd[0].busy_s;
    assign Busy2    = g_rd[1].busy_s;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default 16x16 bypassing instance and a 32x32
// non-bypassing instance share one stimulus and are compared against array models.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  src1, src2, dst, dst2, iss;
    logic [31:0] d1, d2;
    logic        we, we2, iv;

    logic [15:0] a_q1, a_q2;
    logic        a_b1, a_b2;
    logic [31:0] b_q1, b_q2;
    logic        b_b1, b_b2;

    logic [15:0] ma [16];
    logic        pa [16];
    logic [31:0] mb [32];
    logic        pb [32];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst),
        .SrcReg1(src1[3:0]), .SrcReg2(src2[3:0]),
        .SrcData1(a_q1), .SrcData2(a_q2), .Busy1(a_b1), .Busy2(a_b2),
        .DstReg(dst[3:0]), .WriteReg(we), .DstData(d1[15:0]),
        .DstReg2(dst2[3:0]), .WriteReg2(we2), .DstData2(d2[15:0]),
        .IssueReg(iss[3:0]), .IssueValid(iv)
    );

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .SrcReg1(src1), .SrcReg2(src2),
        .SrcData1(b_q1), .SrcData2(b_q2), .Busy1(b_b1), .Busy2(b_b2),
        .DstReg(dst), .WriteReg(we), .DstData(d1),
        .DstReg2(dst2), .WriteReg2(we2), .DstData2(d2),
        .IssueReg(iss), .IssueValid(iv)
    );

    function automatic logic [15:0] exp_a_data(input logic [3:0] ad);
        if (rst || ad == 4'd0) return 16'h0000;
        if (we && dst[3:0] == ad) return d1[15:0];
        if (we2 && dst2[3:0] == ad) return d2[15:0];
        return ma[ad];
    endfunction

    function automatic logic exp_a_busy(input logic [3:0] ad);
        if (rst || ad == 4'd0) return 1'b0;
        return pa[ad] && !((we && dst[3:0] == ad) || (we2 && dst2[3:0] == ad));
    endfunction

    function automatic logic [31:0] exp_b_data(input logic [4:0] ad);
        if (rst || ad == 5'd0) return 32'h0;
        return mb[ad];
    endfunction

    function automatic logic exp_b_busy(input logic [4:0] ad);
        if (rst || ad == 5'd0) return 1'b0;
        return pb[ad];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, " a.data1"}, 32'(a_q1), 32'(exp_a_data(src1[3:0])));
        chk({tag, " a.data2"}, 32'(a_q2), 32'(exp_a_data(src2[3:0])));
        chk({tag, " a.busy1"}, 32'(a_b1), 32'(exp_a_busy(src1[3:0])));
        chk({tag, " a.busy2"}, 32'(a_b2), 32'(exp_a_busy(src2[3:0])));
        chk({tag, " b.data1"}, b_q1, exp_b_data(src1));
        chk({tag, " b.data2"}, b_q2, exp_b_data(src2));
        chk({tag, " b.busy1"}, 32'(b_b1), 32'(exp_b_busy(src1)));
        chk({tag, " b.busy2"}, 32'(b_b2), 32'(exp_b_busy(src2)));
    endtask

    // Advance one clock: update the models at the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin ma[i] = 16'h0; pa[i] = 1'b0; end
            for (int i = 0; i < 32; i++) begin mb[i] = 32'h0; pb[i] = 1'b0; end
        end else begin
            if (we2 && dst2[3:0] != 4'd0) begin ma[dst2[3:0]] = d2[15:0]; pa[dst2[3:0]] = 1'b0; end
            if (we  && dst[3:0]  != 4'd0) begin ma[dst[3:0]]  = d1[15:0]; pa[dst[3:0]]  = 1'b0; end
            if (iv  && iss[3:0]  != 4'd0) pa[iss[3:0]] = 1'b1;
            if (we2 && dst2 != 5'd0) begin mb[dst2] = d2; pb[dst2] = 1'b0; end
            if (we  && dst  != 5'd0) begin mb[dst]  = d1; pb[dst]  = 1'b0; end
            if (iv  && iss  != 5'd0) pb[iss] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; we2 = 1'b0; iv = 1'b0;
        dst = 5'd0; dst2 = 5'd0; iss = 5'd0; d1 = 32'h0; d2 = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin ma[i] = 16'hxxxx; pa[i] = 1'bx; end
        for (int i = 0; i < 32; i++) begin mb[i] = 32'hxxxx_xxxx; pb[i] = 1'bx; end
        idle();
        src1 = 5'd1; src2 = 5'd2;
        rst = 1'b1;
        check_all("reset");
        tick();
        rst = 1'b0;

        // reset then write to reg 1
        we = 1'b1; dst = 5'd1; d1 = 32'h0000_0001;
        check_all("wr1_same");
        tick();
        idle();
        check_all("wr1_next");

        // collision on reg 5
        we = 1'b1; we2 = 1'b1; dst = 5'd5; dst2 = 5'd5; d1 = 32'h0000_AAAA; d2 = 32'h0000_5555;
        src1 = 5'd5; src2 = 5'd1;
        tick();
        idle();
        check_all("collision");

        // zero register: write and issue to 0
        we = 1'b1; dst = 5'd0; d1 = 32'h0000_FACE; iv = 1'b1; iss = 5'd0; src1 = 5'd0; src2 = 5'd0;
        check_all("zero_same");
        tick();
        check_all("zero_next");
        idle();

        // scoreboard on reg 3
        iv = 1'b1; iss = 5'd3; src1 = 5'd3; src2 = 5'd3;
        tick();
        idle();
        check_all("issue_busy");
        we2 = 1'b1; dst2 = 5'd3; d2 = 32'h0000_1234;
        check_all("wb_same");
        tick();
        idle();
        check_all("wb_next");
        iv = 1'b1; iss = 5'd3; we2 = 1'b1; dst2 = 5'd3; d2 = 32'h0000_1234;
        tick();
        idle();
        check_all("issue_and_wb");

        // fill, set pending on 7, then async reset between edges
        for (int i = 1; i < 16; i++) begin
            we = 1'b1; dst = 5'(i); d1 = 32'h1111 * i;
            iv = (i == 15); iss = 5'd7;
            tick();
        end
        idle();
        src1 = 5'd7; src2 = 5'd9;
        check_all("filled");
        #2 rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src1 = 5'(i); src2 = 5'(15 - i);
            we = 1'b1; dst = 5'(i); d1 = 32'hCAFE_0000 + i;
            check_all("async_rst");
        end
        tick();
        idle();
        rst = 1'b0;
        check_all("post_rst");

        // wide instance: reg 31 (reg 15 for the narrow one)
        we = 1'b1; dst = 5'd31; d1 = 32'hDEAD_BEEF; src1 = 5'd31; src2 = 5'd31;
        tick();
        idle();
        check_all("wide31");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            src1 = 5'($urandom); src2 = ($urandom_range(0, 3) == 0) ? src1 : 5'($urandom);
            we = 1'($urandom); we2 = 1'($urandom); iv = 1'($urandom);
            dst = 5'($urandom_range(0, 7)); dst2 = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 7));
            iss = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 7));
            d1 = $urandom; d2 = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            check_all("random");
            tick();
        end
        rst = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
